// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART 8N1 receive deserializer with framing-error and break reporting
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module uart_rx_deserializer #(
    parameter int CLOCK_SCALE_BITS = 16,
    parameter int DATA_BITS        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        dataOut,
    output logic                        dataAvailable,
    output logic                        framingError,
    output logic                        breakDetect,
    output logic                        busy
);
    localparam int IDX_BITS = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_BITS-1:0]         LAST_INDEX = IDX_BITS'(DATA_BITS - 1);
    localparam logic [CLOCK_SCALE_BITS-1:0] MIN_PERIOD = CLOCK_SCALE_BITS'(3);
    localparam logic [CLOCK_SCALE_BITS-1:0] COUNT_ONE  = CLOCK_SCALE_BITS'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rxStateType;

    rxStateType                  state, stateNext;
    logic                        rxMeta, rxs, rxsPrev;
    logic [CLOCK_SCALE_BITS-1:0] counter, counterNext;
    logic [IDX_BITS-1:0]         bitIndex, bitIndexNext;
    logic [DATA_BITS-1:0]        shiftReg, shiftNext;
    logic [DATA_BITS-1:0]        dataOutNext;
    logic                        dataAvailableNext, framingErrorNext, breakDetectNext;
    logic [CLOCK_SCALE_BITS-1:0] period, halfPeriod, startTarget;
    logic                        sampleBit;

    // Periods below 3 leave no room for a centre sample, so they are clamped.
    assign period     = (cyclesPerBit < MIN_PERIOD) ? MIN_PERIOD : cyclesPerBit;
    assign halfPeriod = period >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta  <= 1'b1;
            rxs     <= 1'b1;
            rxsPrev <= 1'b1;
        end else begin
            rxMeta  <= rx;
            rxs     <= rxMeta;
            rxsPrev <= rxs;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxsDly1, rxsDly2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxsDly1 <= 1'b1;
            rxsDly2 <= 1'b1;
        end else begin
            rxsDly1 <= rxs;
            rxsDly2 <= rxsDly1;
        end
    end

    // Deciding one cycle late shifts every later bit decision by one too.
    assign sampleBit   = (rxs & rxsDly1) | (rxs & rxsDly2) | (rxsDly1 & rxsDly2);
    assign startTarget = halfPeriod + COUNT_ONE;
`else
    assign sampleBit   = rxs;
    assign startTarget = halfPeriod;
`endif

    always_comb begin
        stateNext         = state;
        counterNext       = counter + COUNT_ONE;
        bitIndexNext      = bitIndex;
        shiftNext         = shiftReg;
        dataOutNext       = dataOut;
        dataAvailableNext = 1'b0;
        framingErrorNext  = 1'b0;
        breakDetectNext   = breakDetect;
        if (!enable) begin
            stateNext       = IDLE;
            counterNext     = '0;
            bitIndexNext    = '0;
            breakDetectNext = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    counterNext = '0;
                    if (rxsPrev && !rxs) begin
                        stateNext = START;
                    end
                end
                START: begin
                    if (counter >= startTarget) begin
                        counterNext  = '0;
                        bitIndexNext = '0;
                        stateNext    = sampleBit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (counter >= period) begin
                        counterNext         = '0;
                        shiftNext[bitIndex] = sampleBit;
                        if (bitIndex == LAST_INDEX) begin
                            stateNext = STOP;
                        end else begin
                            bitIndexNext = bitIndex + IDX_BITS'(1);
                        end
                    end
                end
                STOP: begin
                    if (counter >= period) begin
                        counterNext = '0;
                        stateNext   = IDLE;
                        if (sampleBit) begin
                            dataOutNext       = shiftReg;
                            dataAvailableNext = 1'b1;
                        end else begin
                            framingErrorNext = 1'b1;
                            // An all-zero frame with a low stop bit is a held-low line.
                            if (shiftReg == '0) begin
                                breakDetectNext = 1'b1;
                                stateNext       = BREAK;
                            end
                        end
                    end
                end
                BREAK: begin
                    counterNext = '0;
                    if (rxs) begin
                        breakDetectNext = 1'b0;
                        stateNext       = IDLE;
                    end
                end
                default: begin
                    stateNext   = IDLE;
                    counterNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            counter       <= '0;
            bitIndex      <= '0;
            shiftReg      <= '0;
            dataOut       <= '0;
            dataAvailable <= 1'b0;
            framingError  <= 1'b0;
            breakDetect   <= 1'b0;
        end else begin
            state         <= stateNext;
            counter       <= counterNext;
            bitIndex      <= bitIndexNext;
            shiftReg      <= shiftNext;
            dataOut       <= dataOutNext;
            dataAvailable <= dataAvailableNext;
            framingError  <= framingErrorNext;
            breakDetect   <= breakDetectNext;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
Serial-to-parallel UART receive front end. Synchronises the asynchronous rx pin, detects start bits, samples 8N1 frames at a runtime-programmable bit period and emits one-cycle byte strobes. Sits directly upstream of the UART device's rx FIFO; dataOut/dataAvailable drive the FIFO dataIn/we inputs. Adds framing-error and line-break reporting for the device status register.

Parameters:
CLOCK_SCALE_BITS, 16, width of cyclesPerBit and the internal bit-period counter
DATA_BITS, 8, data bits per frame (LSB first)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
enable  input  1  receiver enable; low forces IDLE and suppresses all strobes
cyclesPerBit  input  CLOCK_SCALE_BITS  bit period minus one (period = cyclesPerBit+1 clk cycles)
rx  input  1  asynchronous serial input, idle high
dataOut  output  DATA_BITS  last successfully received byte
dataAvailable  output  1  one-cycle strobe, dataOut valid
framingError  output  1  one-cycle strobe, stop bit sampled low
breakDetect  output  1  level, high while a break condition is held
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async): dataOut=0, dataAvailable=0, framingError=0, breakDetect=0, busy=0, state=IDLE, both synchroniser flops=1, counters=0.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs; prior value kept for edge detect.
- Half period = cyclesPerBit>>1. cyclesPerBit<3 is unsupported; the block treats it as 3.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rxs falling edge with enable=1 -> START, counter=0.
- START: count to half period; sample rxs; 1 -> IDLE (glitch rejected, no strobe); 0 -> DATA, counter=0, bitIndex=0.
- DATA: count 0..cyclesPerBit; at terminal count sample into shift register bit bitIndex (LSB first); after DATA_BITS samples -> STOP.
- STOP: at terminal count sample rxs. 1 -> dataOut<=shift register, dataAvailable=1 for exactly the next cycle, -> IDLE. 0 with nonzero data -> framingError pulse, dataOut unchanged, -> IDLE. 0 with all-zero data -> framingError pulse, breakDetect=1, -> BREAK.
- BREAK: hold until rxs=1, then breakDetect=0 -> IDLE. No new start detected while in BREAK.
- Byte latency: dataAvailable asserts 1 cycle after the stop-bit centre sample (approx. 2 sync + 9.5 bit periods after rx falling edge).
- Back-to-back frames: IDLE re-arms immediately after stop-bit sample, so a start edge arriving in the second half of the stop bit is accepted.
- enable deasserted mid-frame: next cycle state=IDLE, partial byte discarded, no strobes, breakDetect cleared; dataOut retained.
- cyclesPerBit change mid-frame: takes effect at next counter compare; frame integrity not guaranteed.
- dataAvailable and framingError never high in the same cycle.

Optional Feature:
UART_RX_MAJORITY_EN: when defined, every start/data/stop sample is the 2-of-3 majority of rxs at centre-1, centre, centre+1 cycles; the decision and all strobes are delayed by 1 cycle relative to single sampling. When undefined, a single sample at the centre cycle is used. Port list identical in both builds.

Test Plan:
- cyclesPerBit=15, send 0xA5 8N1 -> single dataAvailable pulse, dataOut=0xA5, framingError=0, busy low afterwards.
- rx low pulse of 5 cycles (cyclesPerBit=15) -> return to IDLE from START, no dataAvailable/framingError, dataOut unchanged.
- send 0x3C with stop bit forced 0 -> framingError one-cycle pulse, no dataAvailable, dataOut keeps previous 0xA5.
- hold rx low for 20 bit times then release -> framingError pulse, breakDetect high until 2-3 cycles after rx rises, then busy=0; subsequent 0x55 received correctly.
- back-to-back 0x00 then 0xFF with no idle gap -> two dataAvailable pulses 10 bit periods apart, values 0x00, 0xFF.
- assert rst low during DATA of 0x81, release, then send 0x42 -> all outputs 0 during reset, only 0x42 strobed afterwards; repeat with enable dropped mid-frame -> same result.
